regfile_wb_arbiter: RTL and testbench

- Shares the register file's single write port (WE3/A3/WD3) between two writeback requesters: requester 0 (ALU writeback) and requester 1 (load writeback).
- Arbitrates round-robin, discards writes to register $0, and registers the write command.
- Exposes a read-forwarding check so the read ports (A1/A2) can see the write currently in flight.
- Sits between the execute/memory stages and the register file.

---
 rtl/regfile_wb_arbiter_pkg.sv | 15 +
 rtl/regfile_wb_arbiter_rr_arbiter2.sv | 33 +++
 rtl/regfile_wb_arbiter.sv | 81 ++++++++
 tb/tb_regfile_wb_arbiter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
// Requester indices double as bit positions in the grant vector.
package regfile_wb_arbiter_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_ADDR_W = 5;

  localparam logic [DEF_ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_idx_e;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter. The last-winner pointer only advances on
// contested cycles, so an uncontested grant never disturbs the fairness order.
import regfile_wb_arbiter_pkg::*;

module regfile_wb_arbiter_rr_arbiter2 (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  req_idx_e last;

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last == REQ_MEM) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Reset to REQ_MEM so the ALU side wins the first contested cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      last <= REQ_MEM;
    end else if (req == 2'b11) begin
      last <= gnt[REQ_MEM] ? REQ_MEM : REQ_ALU;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port between ALU and load writeback,
// registers the winning write and flags read addresses that hit it.
import regfile_wb_arbiter_pkg::*;

module regfile_wb_arbiter #(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              VLD0,
  input  logic [ADDR_W-1:0] ADDR0,
  input  logic [WIDTH-1:0]  DATA0,
  output logic              RDY0,
  input  logic              VLD1,
  input  logic [ADDR_W-1:0] ADDR1,
  input  logic [WIDTH-1:0]  DATA1,
  output logic              RDY1,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  output logic              WE3,
  output logic [ADDR_W-1:0] A3,
  output logic [WIDTH-1:0]  WD3,
  output logic              FWD1,
  output logic              FWD2,
  output logic              CONFLICT
);

  logic [1:0]        gnt;
  logic              sel_vld;
  logic [ADDR_W-1:0] sel_addr;
  logic [WIDTH-1:0]  sel_data;

  regfile_wb_arbiter_rr_arbiter2 u_arb (
    .CLK (CLK),
    .RST (RST),
    .req ({VLD1, VLD0}),
    .gnt (gnt)
  );

  assign RDY0 = gnt[REQ_ALU];
  assign RDY1 = gnt[REQ_MEM];

  // Only a granted requester's fields are steered, so idle inputs never reach A3/WD3.
  always_comb begin
    sel_vld  = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    if (gnt[REQ_ALU]) begin
      sel_vld  = 1'b1;
      sel_addr = ADDR0;
      sel_data = DATA0;
    end else if (gnt[REQ_MEM]) begin
      sel_vld  = 1'b1;
      sel_addr = ADDR1;
      sel_data = DATA1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      WE3      <= 1'b0;
      A3       <= '0;
      WD3      <= '0;
      CONFLICT <= 1'b0;
    end else begin
      CONFLICT <= VLD0 & VLD1;
      if (sel_vld) begin
        A3  <= sel_addr;
        WD3 <= sel_data;
        WE3 <= (sel_addr != ADDR_W'(REG_ZERO));
      end else begin
        WE3 <= 1'b0;
      end
    end
  end

  assign FWD1 = WE3 & (A1 == A3);
  assign FWD2 = WE3 & (A2 == A3);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: stimulus queues expected grants and
// writes; a negedge monitor pops and checks them one cycle apart.
module tb_regfile_wb_arbiter;

  logic        CLK;
  logic        RST;
  logic        VLD0, VLD1;
  logic [4:0]  ADDR0, ADDR1, A1, A2, A3;
  logic [31:0] DATA0, DATA1, WD3;
  logic        RDY0, RDY1, WE3, FWD1, FWD2, CONFLICT;

  regfile_wb_arbiter dut (
    .CLK(CLK), .RST(RST),
    .VLD0(VLD0), .ADDR0(ADDR0), .DATA0(DATA0), .RDY0(RDY0),
    .VLD1(VLD1), .ADDR1(ADDR1), .DATA1(DATA1), .RDY1(RDY1),
    .A1(A1), .A2(A2),
    .WE3(WE3), .A3(A3), .WD3(WD3),
    .FWD1(FWD1), .FWD2(FWD2), .CONFLICT(CONFLICT)
  );

  typedef struct packed {
    logic [1:0]  rdy;
    logic        we;
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [1:0] r, input logic we, input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    e = {r, we, a, d};
    q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: check the write a granted request produced, then any new grant.
  exp_t pend;
  logic pend_vld = 1'b0;
  always @(negedge CLK) begin
    if (RST) begin
      pend_vld = 1'b0;
    end else begin
      if (pend_vld) begin
        chk("we3", {31'b0, WE3}, {31'b0, pend.we});
        chk("a3", {27'b0, A3}, {27'b0, pend.a});
        chk("wd3", WD3, pend.d);
      end else begin
        chk("we3_idle", {31'b0, WE3}, 32'd0);
      end
      pend_vld = 1'b0;
      if (RDY0 | RDY1) begin
        if (q.size() == 0) begin
          chk("unexpected_rdy", {30'b0, RDY1, RDY0}, 32'd0);
        end else begin
          pend = q.pop_front();
          chk("rdy", {30'b0, RDY1, RDY0}, {30'b0, pend.rdy});
          pend_vld = 1'b1;
        end
      end
    end
  end

  initial begin
    RST = 1'b1; VLD0 = 0; VLD1 = 0; ADDR0 = 0; ADDR1 = 0; DATA0 = 0; DATA1 = 0; A1 = 0; A2 = 0;
    #12;
    chk("rst_we3", {31'b0, WE3}, 32'd0);
    chk("rst_a3", {27'b0, A3}, 32'd0);
    chk("rst_wd3", WD3, 32'd0);
    chk("rst_conflict", {31'b0, CONFLICT}, 32'd0);
    cyc();
    RST = 1'b0;
    repeat (5) cyc();

    // single ALU write
    VLD0 = 1; ADDR0 = 5'd5; DATA0 = 32'hDEADBEEF;
    push(2'b01, 1'b1, 5'd5, 32'hDEADBEEF);
    cyc();
    VLD0 = 0; ADDR0 = 5'h1F; DATA0 = 32'hBAD0BAD0;
    repeat (2) cyc();
    chk("idle_a3_hold", {27'b0, A3}, 32'd5);

    // contention, 4 cycles
    VLD0 = 1; ADDR0 = 5'd3; DATA0 = 32'h11;
    VLD1 = 1; ADDR1 = 5'd4; DATA1 = 32'h22;
    push(2'b01, 1'b1, 5'd3, 32'h11);
    push(2'b10, 1'b1, 5'd4, 32'h22);
    push(2'b01, 1'b1, 5'd3, 32'h11);
    push(2'b10, 1'b1, 5'd4, 32'h22);
    cyc();
    chk("conflict_on", {31'b0, CONFLICT}, 32'd1);
    repeat (3) cyc();
    VLD0 = 0; VLD1 = 0;
    cyc();
    chk("conflict_off", {31'b0, CONFLICT}, 32'd0);
    cyc();

    // write to $0 is accepted but suppressed
    VLD1 = 1; ADDR1 = 5'd0; DATA1 = 32'hFFFF; A1 = 5'd0;
    push(2'b10, 1'b0, 5'd0, 32'hFFFF);
    cyc();
    VLD1 = 0;
    chk("fwd1_zero", {31'b0, FWD1}, 32'd0);
    cyc();

    // forwarding
    VLD0 = 1; ADDR0 = 5'd7; DATA0 = 32'h1234; A1 = 5'd7; A2 = 5'd8;
    push(2'b01, 1'b1, 5'd7, 32'h1234);
    cyc();
    VLD0 = 0;
    chk("fwd1_hit", {31'b0, FWD1}, 32'd1);
    chk("fwd2_miss", {31'b0, FWD2}, 32'd0);
    A2 = 5'd7; #1;
    chk("fwd2_hit", {31'b0, FWD2}, 32'd1);
    cyc();
    chk("fwd1_idle", {31'b0, FWD1}, 32'd0);
    A1 = 0; A2 = 0;

    // same destination: LAST is MEM, so ALU first then MEM overwrites
    VLD0 = 1; ADDR0 = 5'd9; DATA0 = 32'hA;
    VLD1 = 1; ADDR1 = 5'd9; DATA1 = 32'hB;
    push(2'b01, 1'b1, 5'd9, 32'hA);
    push(2'b10, 1'b1, 5'd9, 32'hB);
    cyc();
    VLD0 = 0;
    cyc();
    VLD1 = 0;
    repeat (2) cyc();

    // async reset while a write is in flight
    VLD0 = 1; ADDR0 = 5'd6; DATA0 = 32'h66;
    push(2'b01, 1'b1, 5'd6, 32'h66);
    cyc();
    VLD0 = 0;
    chk("inflight_we3", {31'b0, WE3}, 32'd1);
    #2 RST = 1'b1;
    #1;
    chk("async_we3", {31'b0, WE3}, 32'd0);
    chk("async_a3", {27'b0, A3}, 32'd0);
    cyc();
    cyc();
    RST = 1'b0;
    // pointer is back to its reset value, ALU wins the first contest
    VLD0 = 1; ADDR0 = 5'd1; DATA0 = 32'h1;
    VLD1 = 1; ADDR1 = 5'd2; DATA1 = 32'h2;
    push(2'b01, 1'b1, 5'd1, 32'h1);
    cyc();
    VLD0 = 0; VLD1 = 0;
    repeat (3) cyc();

    chk("queue_drained", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
